// File: rtl/sort_engine.sv
// ----------------------------------------------------------------------------
// sort_engine
//   Buffers a batch of DEPTH unsigned words, bubble-sorts them in place using
//   one shared comparator (one compare per clock), then drains them in order.
//
//   Parameters : WIDTH   data word width (comparator SIZE)
//                DEPTH   words per batch, power of two, >= 2
//                DESCEND 0 = ascending output, 1 = descending output
//   Ports      : clk, rst_n (async, active-low)
//                in_valid / in_ready / in_data     producer handshake
//                out_valid / out_ready / out_data  consumer handshake
//                busy                              high while sorting
//   Macro      : SORT_EARLY_EXIT_EN  leave SORT after any pass with no swap
//
//   Also contains the comparator datapath module the engine is built on.
// ----------------------------------------------------------------------------

module comparator #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            a_larger,
    output logic            equal
);
    assign a_larger = (a > b);
    assign equal    = (a == b);
endmodule

module sort_engine #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int DESCEND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_J   = PW'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     j_q, j_d;
    logic [PW-1:0]     pass_q, pass_d;
    logic [PW-1:0]     j_nxt;
    logic [WIDTH-1:0]  cmp_a, cmp_b;
    logic              a_larger, equal;
    logic              do_swap;
    logic              sort_exit;

    assign j_nxt = j_q + PW'(1);
    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_nxt];

    comparator #(.SIZE(WIDTH)) u_cmp (
        .a        (cmp_a),
        .b        (cmp_b),
        .a_larger (a_larger),
        .equal    (equal)
    );

    // Equal words never swap in either direction, which keeps the sort stable.
    assign do_swap = (DESCEND != 0) ? (!a_larger && !equal) : a_larger;

`ifdef SORT_EARLY_EXIT_EN
    logic swapped_q, swapped_d;
    // Include this cycle's swap: the last compare of a pass may be the only one.
    assign sort_exit = (j_q == LAST_J) && ((pass_q == LAST_J) || !(swapped_q || do_swap));
`else
    assign sort_exit = (j_q == LAST_J) && (pass_q == LAST_J);
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement leaves a latch behind.
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        j_d      = j_q;
        pass_d   = pass_q;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[wr_ptr_q] = in_data;
                    wr_ptr_d        = wr_ptr_q + PW'(1);
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d = SORT;
                        j_d     = '0;
                        pass_d  = '0;
`ifdef SORT_EARLY_EXIT_EN
                        swapped_d = 1'b0;
`endif
                    end
                end
            end
            SORT: begin
                if (do_swap) begin
                    mem_d[j_q]   = cmp_b;
                    mem_d[j_nxt] = cmp_a;
                end
                j_d = j_nxt;
`ifdef SORT_EARLY_EXIT_EN
                swapped_d = swapped_q | do_swap;
`endif
                if (j_q == LAST_J) begin
                    j_d    = '0;
                    pass_d = pass_q + PW'(1);
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                end
                if (sort_exit) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                    pass_d   = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d  = LOAD;
                        wr_ptr_d = '0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the batch array is reset too, so out_data reads 0 after
            // reset and no stale batch can ever be drained.
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            j_q      <= '0;
            pass_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above.
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            j_q      <= j_d;
            pass_q   <= pass_d;
            mem_q    <= mem_d;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q <= swapped_d;
`endif
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == SORT);
    assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sort_engine.sv
// ----------------------------------------------------------------------------
// tb_sort_engine
//   Scoreboard bench: loading a batch pushes its hand-computed sorted result
//   into a queue; monitors pop and compare on each output handshake.
//   Two instances: ascending (main) and DESCEND=1.
// ----------------------------------------------------------------------------
module tb_sort_engine;
    typedef logic [7:0] vec_t [8];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [7:0] a_in_data = '0, a_out_data;
    logic       d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready, d_busy;
    logic [7:0] d_in_data = '0, d_out_data;

    sort_engine #(.WIDTH(8), .DEPTH(8), .DESCEND(0)) u_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    sort_engine #(.WIDTH(8), .DEPTH(8), .DESCEND(1)) u_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .busy(d_busy)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_d [$];
    int a_drained = 0;
    int busy_cnt = 0;
    bit rnd_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: always 1, or about 30% duty when rnd_ready is set.
    initial begin
        a_out_ready = 1'b1;
        d_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Ascending monitor: scoreboard pop, stall hold, no input during drain.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_busy) busy_cnt++;
            if (prev_stall && a_out_valid) check("hold_stable", a_out_data, prev_data);
            if (a_out_valid && a_in_ready) check("in_ready_in_drain", 1, 0);
            if (a_out_valid && a_out_ready) begin
                if (exp_a.size() == 0) check("asc_unexpected_word", 1, 0);
                else check("asc_word", a_out_data, exp_a.pop_front());
                a_drained++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_data  = a_out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && d_out_valid && d_out_ready) begin
            if (exp_d.size() == 0) check("desc_unexpected_word", 1, 0);
            else check("desc_word", d_out_data, exp_d.pop_front());
        end
    end

    task automatic load_a(input vec_t v, input vec_t e, input bit gaps);
        foreach (e[i]) exp_a.push_back(e[i]);
        busy_cnt  = 0;
        a_drained = 0;
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    a_in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            a_in_valid = 1'b1;
            a_in_data  = v[i];
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while ((exp_a.size() != 0 || !a_in_ready) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_out_valid"}, a_out_valid, 0);
        check({name, "_in_ready"},  a_in_ready,  1);
        check({name, "_busy"},      a_busy,      0);
        exp_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #12;
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_busy",      a_busy,      0);
        check("rst_out_data",  a_out_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reverse order: full 49-cycle sort.
        load_a('{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0);
        wait_done_a("reverse");
        check("reverse_busy_cycles", busy_cnt, 49);
        check("reverse_count", a_drained, 8);

        // Presorted: early exit after one pass when the macro is built.
        load_a('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
               '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0);
        wait_done_a("presorted");
`ifdef SORT_EARLY_EXIT_EN
        check("presorted_busy_cycles", busy_cnt, 7);
`else
        check("presorted_busy_cycles", busy_cnt, 49);
`endif

        // Extremes and duplicates.
        load_a('{8'hFF, 8'h00, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01},
               '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF}, 1'b0);
        wait_done_a("extremes");

        // Input gaps and 30% consumer ready.
        rnd_ready = 1'b1;
        load_a('{8'h35, 8'h12, 8'hA0, 8'h12, 8'h00, 8'hFE, 8'h77, 8'h35},
               '{8'h00, 8'h12, 8'h12, 8'h35, 8'h35, 8'h77, 8'hA0, 8'hFE}, 1'b1);
        wait_done_a("stall");
        check("stall_count", a_drained, 8);
        rnd_ready = 1'b0;

        // Reset mid-SORT.
        load_a('{8'd9, 8'd4, 8'd7, 8'd1, 8'd3, 8'd8, 8'd2, 8'd6},
               '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        check("pre_reset_busy", a_busy, 1);
        pulse_reset("rst_sort");

        // Reset at the third drain word.
        load_a('{8'd9, 8'd4, 8'd7, 8'd1, 8'd3, 8'd8, 8'd2, 8'd6},
               '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b0);
        n = 0;
        while (a_drained < 2 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 2000) check("drain_wait_timeout", 1, 0);
        check("third_word_presented", a_out_data, 8'd3);
        pulse_reset("rst_drain");
        check("post_reset_out_data", a_out_data, 0);

        // Full batch after reset.
        load_a('{8'h10, 8'h40, 8'h20, 8'h30, 8'h80, 8'h70, 8'h60, 8'h50},
               '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80}, 1'b0);
        wait_done_a("after_reset");
        check("after_reset_count", a_drained, 8);

        // Descending instance.
        begin
            vec_t dv = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd5, 8'd2, 8'd7};
            vec_t de = '{8'd9, 8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
            foreach (de[i]) exp_d.push_back(de[i]);
            for (int i = 0; i < 8; i++) begin
                d_in_valid = 1'b1;
                d_in_data  = dv[i];
                @(posedge clk);
                #1;
            end
            d_in_valid = 1'b0;
            n = 0;
            while ((exp_d.size() != 0 || !d_in_ready) && n < 3000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 3000) check("desc_timeout", 1, 0);
            check("desc_idle", d_in_ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
